// File: rtl/rr_arbiter_param.sv
// rr_arbiter_param: round-robin arbiter for N requesters with an optional
// hold quota. The grant is combinational from request and the registered
// owner/busy/hold state. Index, one-hot grant and valid are produced together.
//
// Handshake: a requester holds its request bit high for as long as it wants
// the resource. It owns the resource in every cycle where valid is high and
// user equals its index (equivalently grant[i] is high). There is no
// back-pressure and no separate acknowledge.
module rr_arbiter_param #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic [N-1:0]                         request,
    output logic                                 valid,
    output logic [((N > 2) ? $clog2(N) : 1)-1:0] user,
    output logic [N-1:0]                         grant
);

    localparam int IDX_W = (N > 2) ? $clog2(N) : 1;
    localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    // Last granted index. It is reset to N-1 so that the first search starts at 0.
    logic [IDX_W-1:0] owner_reg;
    // This register holds the value of valid from the previous cycle.
    logic             busy_reg;
    logic             expired;
    logic             others;
    logic             owner_req;
    logic             rot_found;
    logic [IDX_W-1:0] rot_idx;
    logic [N-1:0]     owner_onehot;

    assign owner_onehot = {{(N-1){1'b0}}, 1'b1} << owner_reg;
    assign owner_req    = request[owner_reg];
    assign others       = |(request & ~owner_onehot);

    // Cyclic search from owner_reg+1, wrapping modulo N, ending at owner_reg.
    always_comb begin
        int cand;
        rot_found = 1'b0;
        rot_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= N; k++) begin
            cand = int'(owner_reg) + k;
            if (cand >= N) cand = cand - N;
            if (!rot_found && request[cand]) begin
                rot_found = 1'b1;
                rot_idx   = IDX_W'(cand);
            end
        end
    end

    // Decide between idle, persisting with the current owner, or rotating.
    // Reset forces every output to zero regardless of request.
    always_comb begin
        valid = 1'b0;
        user  = '0;
        grant = '0;
        if (reset_n && (|request)) begin
            valid = 1'b1;
            if (busy_reg && owner_req && !(expired && others))
                user = owner_reg;
            else
                user = rot_idx;
            grant = {{(N-1){1'b0}}, 1'b1} << user;
        end
    end

    // Track the previous valid and the fairness pointer. Idle leaves the pointer alone.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            owner_reg <= IDX_W'(N - 1);
            busy_reg  <= 1'b0;
        end else begin
            busy_reg <= valid;
            if (valid) owner_reg <= user;
        end
    end

    generate
        if (MAX_HOLD == 0) begin : g_no_quota
            assign expired = 1'b0;
        end else begin : g_quota
            logic [CNT_W-1:0] hold_cnt;

            assign expired = (hold_cnt >= CNT_W'(MAX_HOLD));

            // Count consecutive cycles of the same owner. The count saturates at the quota.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    hold_cnt <= '0;
                end else if (!valid) begin
                    hold_cnt <= '0;
                end else if (!busy_reg || (user != owner_reg)) begin
                    hold_cnt <= CNT_W'(1);
                end else if (hold_cnt < CNT_W'(MAX_HOLD)) begin
                    hold_cnt <= hold_cnt + CNT_W'(1);
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_rr_arbiter_param.sv
// tb_rr_arbiter_param: directed scoreboard bench for three arbiter instances.
// The instances are a: N=4 with no quota, b: N=4 with MAX_HOLD=3, and c: N=5 with MAX_HOLD=8.
module tb_rr_arbiter_param;

    localparam int W = 9;  // packed {valid, user[2:0], grant[4:0]}

    logic       clock;
    logic       rst_a, rst_b, rst_c;
    logic [3:0] req_a, req_b;
    logic [4:0] req_c;
    logic       valid_a, valid_b, valid_c;
    logic [1:0] user_a, user_b;
    logic [2:0] user_c;
    logic [3:0] grant_a, grant_b;
    logic [4:0] grant_c;

    logic [W-1:0] exp_a[$];
    logic [W-1:0] exp_b[$];
    logic [W-1:0] exp_c[$];
    logic [W-1:0] exp_r[$];

    int n_checks;
    int n_fail;

    wire [W-1:0] act_a = {valid_a, 1'b0, user_a, 1'b0, grant_a};
    wire [W-1:0] act_b = {valid_b, 1'b0, user_b, 1'b0, grant_b};
    wire [W-1:0] act_c = {valid_c, user_c, grant_c};

    rr_arbiter_param #(.N(4), .MAX_HOLD(0)) dut_a (
        .clock(clock), .reset_n(rst_a), .request(req_a),
        .valid(valid_a), .user(user_a), .grant(grant_a)
    );

    rr_arbiter_param #(.N(4), .MAX_HOLD(3)) dut_b (
        .clock(clock), .reset_n(rst_b), .request(req_b),
        .valid(valid_b), .user(user_b), .grant(grant_b)
    );

    rr_arbiter_param #(.N(5), .MAX_HOLD(8)) dut_c (
        .clock(clock), .reset_n(rst_c), .request(req_c),
        .valid(valid_c), .user(user_c), .grant(grant_c)
    );

    // Clock and reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [W-1:0] pk(input logic v, input logic [2:0] u, input logic [4:0] g);
        return {v, u, g};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got valid=%0b user=%0d grant=%b, want valid=%0b user=%0d grant=%b",
                     name, $time, act[8], act[7:5], act[4:0], exp[8], exp[7:5], exp[4:0]);
        end
    endtask

    // Monitor: it pops once per negedge for each instance and handles mid-cycle reset checks.
    always begin
        @(negedge clock or negedge rst_b);
        if (clock == 1'b0) begin
            if (exp_a.size() > 0) check("dut_a", act_a, exp_a.pop_front());
            if (exp_b.size() > 0) check("dut_b", act_b, exp_b.pop_front());
            if (exp_c.size() > 0) check("dut_c", act_c, exp_c.pop_front());
        end else begin
            #1;
            if (exp_r.size() > 0) check("reset_pulse_b", act_b, exp_r.pop_front());
        end
    end

    // Driver: it applies a request to one instance and queues the expected response.
    task automatic drive(input int d, input logic [4:0] r, input logic v,
                         input logic [2:0] u, input logic [4:0] g);
        @(posedge clock);
        #1;
        case (d)
            0: begin req_a = r[3:0]; exp_a.push_back(pk(v, u, g)); end
            1: begin req_b = r[3:0]; exp_b.push_back(pk(v, u, g)); end
            default: begin req_c = r; exp_c.push_back(pk(v, u, g)); end
        endcase
    endtask

    logic [1:0] quota_users [9];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        req_a = 4'b1010; req_b = 4'b0000; req_c = 5'b00000;
        quota_users = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};

        // Reset with a pending request: outputs stay zero
        drive(0, 5'b01010, 1'b0, 3'd0, 5'b00000);
        drive(0, 5'b01010, 1'b0, 3'd0, 5'b00000);

        // Release: the first grant is in the same cycle, and it persists while bit 1 is held
        @(posedge clock);
        #1;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        exp_a.push_back(pk(1'b1, 3'd1, 5'b00010));
        for (int i = 0; i < 3; i++) drive(0, 5'b01010, 1'b1, 3'd1, 5'b00010);

        // Re-reset a, then rotate on drop 0 -> 1 -> 2 -> 3 -> 0
        @(posedge clock);
        #1;
        rst_a = 1'b0;
        req_a = 4'b1111;
        exp_a.push_back(pk(1'b0, 3'd0, 5'b00000));
        @(posedge clock);
        #1;
        rst_a = 1'b1;
        exp_a.push_back(pk(1'b1, 3'd0, 5'b00001));
        drive(0, 5'b01111, 1'b1, 3'd0, 5'b00001);
        drive(0, 5'b01110, 1'b1, 3'd1, 5'b00010);
        drive(0, 5'b01111, 1'b1, 3'd1, 5'b00010);
        drive(0, 5'b01101, 1'b1, 3'd2, 5'b00100);
        drive(0, 5'b01111, 1'b1, 3'd2, 5'b00100);
        drive(0, 5'b01011, 1'b1, 3'd3, 5'b01000);
        drive(0, 5'b01111, 1'b1, 3'd3, 5'b01000);
        drive(0, 5'b00111, 1'b1, 3'd0, 5'b00001);
        drive(0, 5'b01111, 1'b1, 3'd0, 5'b00001);

        // Idle preserves the pointer: the search after owner 2 starts at 3 and wraps to 0
        drive(0, 5'b00100, 1'b1, 3'd2, 5'b00100);
        for (int i = 0; i < 3; i++) drive(0, 5'b00000, 1'b0, 3'd0, 5'b00000);
        drive(0, 5'b00101, 1'b1, 3'd0, 5'b00001);
        drive(0, 5'b00000, 1'b0, 3'd0, 5'b00000);

        // Quota of 3 under contention
        for (int i = 0; i < 9; i++) begin
            logic [2:0] u;
            u = {1'b0, quota_users[i]};
            drive(1, 5'b00011, 1'b1, u, (u == 3'd0) ? 5'b00001 : 5'b00010);
        end
        // A sole requester keeps the grant even though its quota has expired
        for (int i = 0; i < 12; i++) drive(1, 5'b00001, 1'b1, 3'd0, 5'b00001);

        // Owner 2 takes over, and reset is pulsed during its second hold cycle
        drive(1, 5'b00100, 1'b1, 3'd2, 5'b00100);
        drive(1, 5'b00100, 1'b1, 3'd2, 5'b00100);
        #1;
        exp_r.push_back(pk(1'b0, 3'd0, 5'b00000));
        rst_b = 1'b0;
        #2;
        rst_b = 1'b1;
        // The pulse cycle is hold cycle 1. Two more cycles follow, then it yields to 1
        drive(1, 5'b00110, 1'b1, 3'd2, 5'b00100);
        drive(1, 5'b00110, 1'b1, 3'd2, 5'b00100);
        drive(1, 5'b00110, 1'b1, 3'd1, 5'b00010);
        drive(1, 5'b00000, 1'b0, 3'd0, 5'b00000);

        // N=5: the wrap is modulo 5
        drive(2, 5'b10000, 1'b1, 3'd4, 5'b10000);
        drive(2, 5'b10011, 1'b1, 3'd4, 5'b10000);
        drive(2, 5'b00011, 1'b1, 3'd0, 5'b00001);
        drive(2, 5'b00011, 1'b1, 3'd0, 5'b00001);
        drive(2, 5'b00010, 1'b1, 3'd1, 5'b00010);
        drive(2, 5'b10001, 1'b1, 3'd4, 5'b10000);
        drive(2, 5'b00001, 1'b1, 3'd0, 5'b00001);
        drive(2, 5'b00000, 1'b0, 3'd0, 5'b00000);

        // Final report
        @(posedge clock);
        @(posedge clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
